// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the instruction-fetch stage.
//   XLEN          - width of the PC and instruction fields in a buffered entry
//   INSTR_BYTES   - PC increment per sequential fetch
//   NOP_INSTR     - canonical no-op encoding (addi x0,x0,0)
//   fetch_entry_t - one buffered fetch: {pc, instr}
//   fifo_state_e  - occupancy class of the fetch buffer
//   branch_target - redirect target, word aligned
package fetch_pkg;
  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FIFO_EMPTY,
    FIFO_PARTIAL,
    FIFO_FULL
  } fifo_state_e;

  // Branch PC plus offset, low two bits cleared so the target is word aligned.
  function automatic logic [XLEN-1:0] branch_target(input logic [XLEN-1:0] base,
                                                    input logic [XLEN-1:0] imm);
    logic [XLEN-1:0] sum;
    sum = base + imm;
    return {sum[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request/response, branch redirect and the
// downstream valid/ready instruction handshake of the fetch stage.
//   master modport: the fetch unit.  slave modport: memory + decode side.
interface fetch_if #(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  imem_req;
  logic [PC_WIDTH-1:0]   imem_addr;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  redirect;
  logic [PC_WIDTH-1:0]   redirect_base;
  logic [DATA_WIDTH-1:0] redirect_imm;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr;
  logic [PC_WIDTH-1:0]   instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_rdata, redirect, redirect_base, redirect_imm, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_rdata, redirect, redirect_base, redirect_imm, instr_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular buffer of fetch_entry_t with registered head.
//   clk, rst      - clock, synchronous active-high reset (clears storage)
//   flush_i       - synchronous empty; beats push and pop in the same cycle
//   push_i/_entry - write one entry at the tail
//   pop_i         - drop the head
//   valid_o       - head holds a live entry
//   head_o        - head entry, read straight from storage registers
//   count_o       - number of live entries
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush_i,
  input  logic                           push_i,
  input  fetch_entry_t                   push_entry_i,
  input  logic                           pop_i,
  output logic                           valid_o,
  output fetch_entry_t                   head_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_entry_t     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  fifo_state_e      state_c;

  // Storage and pointers; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Occupancy class derived from the count.
  always_comb begin
    state_c = FIFO_PARTIAL;
    if (count_q == '0) state_c = FIFO_EMPTY;
    else if (count_q == CNT_W'(FIFO_DEPTH)) state_c = FIFO_FULL;
  end

  assign valid_o = (state_c != FIFO_EMPTY);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Holds the PC, issues reads to a
// 1-cycle-latency instruction memory, buffers returned words with their PCs
// and hands them downstream over valid/ready. Branch redirects flush.
//   clk, rst - clock, synchronous active-high reset
//   bus      - fetch_if.master: imem_req/imem_addr/imem_rdata,
//              redirect/redirect_base/redirect_imm,
//              instr_valid/instr_ready/instr/instr_pc
//   perf_fetched, perf_flushed - 32-bit event counters, present only when
//              FETCH_PERF_EN is defined
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned          PC_WIDTH   = 32,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0,
  parameter int unsigned          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  fetch_if.master     bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-1:0] inflight_pc_q;
  logic                inflight_q;
  logic [CNT_W-1:0]    count;
  logic                head_valid;
  fetch_entry_t        head;
  fetch_entry_t        push_entry;
  logic                pop_c;
  logic                push_c;
  logic                issue_c;
  logic [OCC_W-1:0]    occ_c;

  // Issue only if the response is guaranteed a slot after this cycle's pop.
  assign pop_c   = head_valid & bus.instr_ready;
  assign occ_c   = OCC_W'(count) + OCC_W'(inflight_q) - OCC_W'(pop_c);
  assign issue_c = !rst && !bus.redirect && (occ_c < OCC_W'(FIFO_DEPTH));
  // A redirect kills the response returning this cycle.
  assign push_c  = inflight_q && !bus.redirect;

  assign push_entry = '{pc: XLEN'(inflight_pc_q), instr: XLEN'(bus.imem_rdata)};

  // Next PC: redirect target beats sequential advance.
  always_comb begin
    pc_d = pc_q;
    if (bus.redirect)
      pc_d = PC_WIDTH'(branch_target(XLEN'(bus.redirect_base), XLEN'(bus.redirect_imm)));
    else if (issue_c)
      pc_d = pc_q + PC_WIDTH'(INSTR_BYTES);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= issue_c;
      if (issue_c) inflight_pc_q <= pc_q;
    end
  end

  fetch_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (bus.redirect),
    .push_i      (push_c),
    .push_entry_i(push_entry),
    .pop_i       (pop_c),
    .valid_o     (head_valid),
    .head_o      (head),
    .count_o     (count)
  );

  assign bus.imem_req    = issue_c;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = head_valid;
  assign bus.instr       = DATA_WIDTH'(head.instr);
  assign bus.instr_pc    = PC_WIDTH'(head.pc);

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_flushed_q;

  // Flushed = buffered entries discarded plus the killed in-flight response.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      if (push_c) perf_fetched_q <= perf_fetched_q + 32'(1);
      if (bus.redirect)
        perf_flushed_q <= perf_flushed_q + 32'(count) + 32'(inflight_q);
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif
endmodule
